// File: rtl/ex_md_pkg.sv
// Shared types and constants for the EX-stage iterative multiply/divide unit.
package ex_md_pkg;

  localparam int MD_STEPS = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_md_iter.sv
// Per-cycle magnitude datapath: shift-add multiply or restoring divide on a 64-bit
// accumulator whose low half starts as the multiplier/dividend.
module ex_md_iter
  import ex_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_opa,
  input  logic [XLEN-1:0]   i_opb,
  output logic [2*XLEN-1:0] o_acc_next,
  output logic              o_last
);

  localparam int CNT_W = $clog2(MD_STEPS);

  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_opa;
  logic [2*XLEN-1:0] r_acc;
  logic              r_is_div;

  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_div_next;

  // Multiply: add multiplicand into the high half when the low bit is set, shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opa} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: shift left one bit, subtract divisor if it fits; the shifted remainder
  // needs XLEN+1 bits since it can exceed 2^XLEN-1 before the subtraction.
  assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff     = w_rem_sh - {1'b0, r_opa};
  assign w_ge       = (w_rem_sh >= {1'b0, r_opa});
  assign w_div_next = w_ge ? {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                           : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

  assign o_acc_next = r_is_div ? w_div_next : w_mul_next;
  assign o_last     = (r_cnt == CNT_W'(MD_STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_opa    <= '0;
      r_acc    <= '0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= '0;
      r_opa    <= i_opa;
      r_acc    <= {{XLEN{1'b0}}, i_opb};
      r_is_div <= i_is_div;
    end else if (i_step) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_acc    <= o_acc_next;
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M multiply/divide sequencer beside the EX ALU: stalls the pipe while iterating
// and presents a registered result in the cycle the stall drops.
module ex_muldiv_seq
  import ex_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            MD_start,
  input  logic [2:0]      MD_op,
  input  logic [XLEN-1:0] MD_op1,
  input  logic [XLEN-1:0] MD_op2,
  input  logic            EX_Flush,
  output logic            MD_stall,
  output logic            MD_busy,
  output logic            MD_done,
  output logic [XLEN-1:0] MD_result
);

  md_state_e r_state, w_state_next;
  md_op_e    r_op, w_op;
  logic      r_neg_pq, r_neg_rem, r_busy, r_done;
  logic [XLEN-1:0] r_result;

  logic w_sgn1, w_sgn2, w_neg1, w_neg2;
  logic w_div0, w_ovf, w_special, w_accept, w_load, w_step, w_last, w_finish;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_special_res, w_final, w_quo, w_rem;
  logic [2*XLEN-1:0] w_acc_next, w_prod;

  assign w_op   = md_op_e'(MD_op);
  assign w_sgn1 = (w_op == MD_MULH) || (w_op == MD_MULHSU) || (w_op == MD_DIV) || (w_op == MD_REM);
  assign w_sgn2 = (w_op == MD_MULH) || (w_op == MD_DIV) || (w_op == MD_REM);
  assign w_neg1 = w_sgn1 && MD_op1[XLEN-1];
  assign w_neg2 = w_sgn2 && MD_op2[XLEN-1];
  assign w_mag1 = w_neg1 ? -MD_op1 : MD_op1;
  assign w_mag2 = w_neg2 ? -MD_op2 : MD_op2;

  assign w_div0    = MD_op[2] && (MD_op2 == '0);
  assign w_ovf     = (w_op == MD_DIV || w_op == MD_REM) && (MD_op1 == INT_MIN) && (MD_op2 == '1);
  assign w_special = w_div0 || w_ovf;

  // MD_op[1] distinguishes REM/REMU from DIV/DIVU
  always_comb begin
    w_special_res = DIV0_QUOT;
    if (w_div0) w_special_res = MD_op[1] ? MD_op1 : DIV0_QUOT;
    else        w_special_res = MD_op[1] ? '0 : INT_MIN;
  end

  assign w_accept = (r_state == IDLE) && MD_start && !EX_Flush;
  assign w_load   = w_accept && !w_special;
  assign w_step   = (r_state == BUSY) && !EX_Flush;
  assign w_finish = w_step && w_last;

  ex_md_iter #(.XLEN(XLEN)) u_iter (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_is_div   (MD_op[2]),
    .i_opa      (w_mag2),
    .i_opb      (w_mag1),
    .o_acc_next (w_acc_next),
    .o_last     (w_last)
  );

  // Sign correction applied to the final step's accumulator value
  assign w_prod = r_neg_pq  ? -w_acc_next : w_acc_next;
  assign w_quo  = r_neg_pq  ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
  assign w_rem  = r_neg_rem ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    w_final = w_rem;
    case (r_op)
      MD_MUL:                        w_final = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  w_final = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               w_final = w_quo;
      default:                       w_final = w_rem;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_special ? DONE : BUSY;
      BUSY:    if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (EX_Flush) w_state_next = IDLE;
  end

  always_comb begin
    MD_stall  = w_accept || (r_state == BUSY);
    MD_busy   = r_busy;
    MD_done   = r_done;
    MD_result = r_result;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_op      <= MD_MUL;
      r_neg_pq  <= 1'b0;
      r_neg_rem <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_busy <= (w_state_next != IDLE);
      r_done <= (w_state_next == DONE);
      if (w_accept) begin
        r_op      <= w_op;
        r_neg_pq  <= w_neg1 ^ w_neg2;
        r_neg_rem <= w_neg1;
      end
      if (w_accept && w_special) r_result <= w_special_res;
      else if (w_finish)         r_result <= w_final;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed table-driven bench for ex_muldiv_seq plus flush/reset/back-to-back sequences.
module tb_ex_muldiv_seq;
  import ex_md_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        MD_start = 1'b0;
  logic        EX_Flush = 1'b0;
  logic [2:0]  MD_op = 3'b000;
  logic [31:0] MD_op1 = '0;
  logic [31:0] MD_op2 = '0;
  logic        MD_stall, MD_busy, MD_done;
  logic [31:0] MD_result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  ex_muldiv_seq #(.XLEN(32)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .MD_start  (MD_start),
    .MD_op     (MD_op),
    .MD_op1    (MD_op1),
    .MD_op2    (MD_op2),
    .EX_Flush  (EX_Flush),
    .MD_stall  (MD_stall),
    .MD_busy   (MD_busy),
    .MD_done   (MD_done),
    .MD_result (MD_result)
  );

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          exp_done;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after DONE (or after 40 cycles).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, output logic [31:0] res, output int done_cyc,
                        output int stall_cnt, output int stall_last,
                        output logic busy_at_flush, output logic busy_after_flush);
    MD_op = op; MD_op1 = a; MD_op2 = b; MD_start = 1'b1;
    res = '0; done_cyc = -1; stall_cnt = 0; stall_last = -1;
    busy_at_flush = 1'b0; busy_after_flush = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == flush_at) EX_Flush = 1'b1;
      else if (flush_at >= 0 && c == flush_at + 1) begin
        EX_Flush = 1'b0;
        MD_start = 1'b0;
      end
      #1;
      if (MD_stall) begin stall_cnt++; stall_last = c; end
      if (c == flush_at) busy_at_flush = MD_busy;
      if (flush_at >= 0 && c == flush_at + 1) busy_after_flush = MD_busy;
      if (MD_done && done_cyc < 0) begin
        done_cyc = c;
        res = MD_result;
        MD_start = 1'b0;
      end
      @(negedge Clk);
      if (done_cyc >= 0) break;
    end
    MD_start = 1'b0;
    EX_Flush = 1'b0;
    $display("op=%0d a=%h b=%h flush_at=%0d result=%h done_cycle=%0d stall_cycles=%0d",
             op, a, b, flush_at, res, done_cyc, stall_cnt);
  endtask

  logic [31:0] res;
  int dc, sc, sl;
  logic bf0, bf1;

  initial begin
    vecs[0]  = '{MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[2]  = '{MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[3]  = '{MD_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{MD_DIVU,   32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{MD_REMU,   32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{MD_REMU,   32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{MD_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33};
    vecs[13] = '{MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[14] = '{MD_DIV,    32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 33};
    vecs[15] = '{MD_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[16] = '{MD_DIVU,   32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1};

    // Reset state
    #2;
    chk("reset busy",   {31'b0, MD_busy},  32'd0);
    chk("reset done",   {31'b0, MD_done},  32'd0);
    chk("reset stall",  {31'b0, MD_stall}, 32'd0);
    chk("reset result", MD_result,         32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, res, dc, sc, sl, bf0, bf1);
      chk($sformatf("v%0d result", i),     res, vecs[i].exp);
      chk($sformatf("v%0d done_cycle", i), dc,  vecs[i].exp_done);
      chk($sformatf("v%0d stall_cnt", i),  sc,  vecs[i].exp_done);
      chk($sformatf("v%0d stall_last", i), sl,  vecs[i].exp_done - 1);
    end

    // Flush mid-divide: result from the preceding DIVU must survive
    run_op(MD_DIVU, 32'd100, 32'd7, -1, res, dc, sc, sl, bf0, bf1);
    chk("pre-flush divu", res, 32'd14);
    run_op(MD_DIVU, 32'hFFFF_FFFF, 32'd3, 10, res, dc, sc, sl, bf0, bf1);
    chk("flush busy at cycle 10",  {31'b0, bf0}, 32'd1);
    chk("flush busy at cycle 11",  {31'b0, bf1}, 32'd0);
    chk("flush no done",           dc, 32'hFFFF_FFFF);
    chk("flush result kept",       MD_result, 32'd14);

    // Flush and start together: nothing starts
    MD_op = MD_MUL; MD_op1 = 32'd9; MD_op2 = 32'd9; MD_start = 1'b1; EX_Flush = 1'b1;
    #1;
    chk("flush+start stall", {31'b0, MD_stall}, 32'd0);
    @(negedge Clk);
    chk("flush+start busy", {31'b0, MD_busy}, 32'd0);
    chk("flush+start done", {31'b0, MD_done}, 32'd0);
    MD_start = 1'b0; EX_Flush = 1'b0;
    $display("flush+start same cycle: busy=%0d result=%h", MD_busy, MD_result);

    run_op(MD_MUL, 32'd3, 32'd4, -1, res, dc, sc, sl, bf0, bf1);
    chk("mul 3x4 result", res, 32'd12);
    chk("mul 3x4 done",   dc,  32'd33);

    // Asynchronous reset mid-BUSY
    MD_op = MD_MUL; MD_op1 = 32'h1234; MD_op2 = 32'd5; MD_start = 1'b1;
    repeat (15) @(negedge Clk);
    #2;
    chk("busy before reset", {31'b0, MD_busy}, 32'd1);
    MD_start = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("async reset busy",   {31'b0, MD_busy},  32'd0);
    chk("async reset done",   {31'b0, MD_done},  32'd0);
    chk("async reset stall",  {31'b0, MD_stall}, 32'd0);
    chk("async reset result", MD_result,         32'd0);
    $display("async reset mid-busy: busy=%0d done=%0d result=%h", MD_busy, MD_done, MD_result);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Back-to-back multiplies: second start in the cycle after DONE
    run_op(MD_MUL, 32'd6, 32'd7, -1, res, dc, sc, sl, bf0, bf1);
    chk("b2b first result", res, 32'd42);
    chk("b2b first done",   dc,  32'd33);
    run_op(MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, res, dc, sc, sl, bf0, bf1);
    chk("b2b second result", res, 32'd1);
    chk("b2b second done",   dc,  32'd33);
    chk("b2b second stall",  sc,  32'd33);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Iterative RV32M multiply/divide sequencer that sits beside the EX-stage ALU. It accepts an M-extension operation with already-forwarded operands, stalls the pipeline while it runs a 32-step shift-add or restoring-divide loop, and presents a registered result in the cycle the stall drops so the EX pipeline register captures it like an ALU result. It is the only multi-cycle resource in EX.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- Clk  in  1  clock; single clock domain.
- Reset_n  in  1  reset; asynchronous, active-low.
- MD_start  in  1  an M-ext instruction is in ID/EX; held high until its result is captured.
- MD_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- MD_op1  in  32  rs1 value, post-forwarding.
- MD_op2  in  32  rs2 value, post-forwarding.
- EX_Flush  in  1  aborts any operation in progress.
- MD_stall  out  1  hold PC/IF/ID/EX registers; combinational.
- MD_busy  out  1  state is not IDLE; registered.
- MD_done  out  1  single-cycle pulse, result valid; registered.
- MD_result  out  32  result; holds its value until the next DONE.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: on MD_start=1 and EX_Flush=0, latch the operation, the absolute-value operands, the sign flags and the special-case flags.
  - Go to DONE if a special case applies; otherwise go to BUSY with step counter = 0.
- BUSY:
  - One iteration per cycle. Multiply: 64-bit shift-add on magnitudes. Divide: restoring, 1 quotient bit per cycle.
  - On step 31, apply sign correction, load MD_result, go to DONE.
- DONE: MD_done=1. MD_start is ignored in this cycle. Go to IDLE.
- MD_stall = (IDLE and MD_start and not EX_Flush) or BUSY. It is 0 in DONE.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/REM: both signed.
  - Product is negated when the operand signs differ. Quotient is negated when the signs differ. Remainder takes the sign of the dividend.
- Result selection: MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32]. All arithmetic is modulo 2^32/2^64 with no traps.
- Special cases (no iteration):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op1.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: DIV returns 0x80000000, REM returns 0.
- Flush: EX_Flush=1 in any state sends the block to IDLE on the next edge. No MD_done pulse follows. MD_result is unchanged.
- Reset: asynchronous. State=IDLE; MD_busy, MD_done, MD_result = 0. The internal counter and accumulators are cleared.

## Timing
- Start is sampled in cycle 0.
- Normal operation: BUSY in cycles 1–32, DONE in cycle 33. MD_stall is high in cycles 0–32.
- Special case: DONE in cycle 1. MD_stall is high in cycle 0 only.
- The EX register captures MD_result at the end of the DONE cycle.
- Back-to-back M-ext instructions: the next start is sampled in the cycle after DONE.
- Flush and start in the same cycle: flush wins and no operation starts.
- Reset asserted mid-operation returns to IDLE immediately; no partial result is visible.

## Structure
- Shared package ex_md_pkg:
  - md_op_e enum (the 8 funct3 encodings).
  - md_state_e (IDLE/BUSY/DONE).
  - MD_STEPS=32.
  - Constants DIV0_QUOT=32'hFFFFFFFF and INT_MIN=32'h80000000.
- One sub-module, ex_md_iter, holds the per-cycle datapath (shift-add / restoring step, 64-bit accumulator, counter).
- The FSM, special-case detection and sign correction stay in ex_muldiv_seq.

## Test plan
- MUL 7×(−3), i.e. 0x00000007 × 0xFFFFFFFD -> MD_result 0xFFFFFFEB; MD_done in cycle 33; MD_stall high in cycles 0–32 exactly.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH on the same operands -> 0x00000000. MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD. REM −7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each done in cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, done in cycle 1.
- Start DIVU, assert EX_Flush in cycle 10 -> MD_busy=0 from cycle 11, no MD_done pulse, MD_result retains its previous value. Then start MUL 3×4 -> 12.
- Deassert Reset_n asynchronously mid-BUSY -> all outputs 0 immediately. Two back-to-back MULs after release both complete with correct results and no skipped start.
